// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: opcode values, instruction field positions and the decode bundle.
// Included by decode_stage and regfile_2r1w.
package decode_pkg;

    localparam int BUS_W    = 32;
    localparam int RADDR_W  = 5;
    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OPC_NOP  = 6'd0;
    localparam logic [OPCODE_W-1:0] OPC_ADD  = 6'd1;
    localparam logic [OPCODE_W-1:0] OPC_ADDI = 6'd2;
    localparam logic [OPCODE_W-1:0] OPC_LW   = 6'd3;
    localparam logic [OPCODE_W-1:0] OPC_SW   = 6'd4;
    localparam logic [OPCODE_W-1:0] OPC_BEQ  = 6'd5;
    localparam logic [OPCODE_W-1:0] OPC_MAC  = 6'd6;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [OPCODE_W-1:0] opc;
        logic [RADDR_W-1:0]  rd;
        logic [BUS_W-1:0]    rs_val;
        logic [BUS_W-1:0]    rt_val;
        logic [BUS_W-1:0]    imm;
        logic [BUS_W-1:0]    pc;
        logic                illegal;
    } decode_bundle_t;

    // Opcodes whose rt field names a real source register (ADDI/LW reuse those bits as immediate).
    function automatic logic uses_rt(input logic [OPCODE_W-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SW) || (opc == OPC_BEQ) || (opc == OPC_MAC);
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file with two asynchronous read ports and one synchronous write port; r0 reads as zero.
// Macro DECODE_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile_2r1w
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (addr == '0) return '0;
`ifdef DECODE_BYPASS_EN
        if (we_i && (waddr_i == addr)) return wdata_i;
`endif
        return mem_q[addr];
    endfunction

    assign rdata_a_o = read_port(raddr_a_i);
    assign rdata_b_o = read_port(raddr_b_i);

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: field decode, register read, load-use hazard stall and registered output bundle.
// Same-cycle write-to-read forwarding is enabled by defining DECODE_BYPASS_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OPC_W      = 6
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BUS_WIDTH-1:0]  in_instr,
    input  logic [BUS_WIDTH-1:0]  in_pc,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [BUS_WIDTH-1:0]  wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPC_W-1:0]      out_opc,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [BUS_WIDTH-1:0]  out_rs_val,
    output logic [BUS_WIDTH-1:0]  out_rt_val,
    output logic [BUS_WIDTH-1:0]  out_imm,
    output logic [BUS_WIDTH-1:0]  out_pc,
    output logic                  out_illegal,
    output logic [BUS_WIDTH-1:0]  stall_cnt
);

    logic [OPC_W-1:0]      opc_w;
    logic [REG_ADDR_W-1:0] rd_w, rs_w, rt_w;
    logic [BUS_WIDTH-1:0]  rs_val_w, rt_val_w;
    logic                  hazard, load_en, accept;
    decode_bundle_t        dec_w, bundle_q, bundle_d;
    logic                  out_valid_q, out_valid_d;
    logic [BUS_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

    assign opc_w = in_instr[OPC_MSB:OPC_LSB];
    assign rd_w  = in_instr[RD_MSB:RD_LSB];
    assign rs_w  = in_instr[RS_MSB:RS_LSB];
    assign rt_w  = in_instr[RT_MSB:RT_LSB];

    regfile_2r1w #(
        .DATA_W (BUS_WIDTH),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_w),
        .raddr_b_i (rt_w),
        .rdata_a_o (rs_val_w),
        .rdata_b_o (rt_val_w)
    );

    always_comb begin
        dec_w         = '0;
        dec_w.opc     = opc_w;
        dec_w.rd      = rd_w;
        dec_w.rs_val  = rs_val_w;
        dec_w.rt_val  = rt_val_w;
        dec_w.imm     = {{(BUS_WIDTH-16){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:IMM_LSB]};
        dec_w.pc      = in_pc;
        dec_w.illegal = (opc_w > OPC_MAC);
    end

    // A held LW whose destination feeds the incoming instruction must leave before that instruction reads.
    assign hazard = out_valid_q && (bundle_q.opc == OPC_LW) && (bundle_q.rd != '0) &&
                    ((bundle_q.rd == rs_w) || (uses_rt(opc_w) && (bundle_q.rd == rt_w)));

    assign load_en  = !out_valid_q || out_ready;
    assign in_ready = !hazard && load_en && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        stall_cnt_d = stall_cnt_q + {{(BUS_WIDTH-1){1'b0}}, (in_valid && hazard)};
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load_en) begin
            // The all-zero word is a bubble: consumed but never presented downstream.
            out_valid_d = accept && (in_instr != '0);
            if (accept && (in_instr != '0)) bundle_d = dec_w;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opc     = bundle_q.opc;
    assign out_rd      = bundle_q.rd;
    assign out_rs_val  = bundle_q.rs_val;
    assign out_rt_val  = bundle_q.rt_val;
    assign out_imm     = bundle_q.imm;
    assign out_pc      = bundle_q.pc;
    assign out_illegal = bundle_q.illegal;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, load-use stall, backpressure, flush, write/read timing, bubbles, reset.
// Expected operand for a same-cycle write/read follows DECODE_BYPASS_EN.
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_opc;
    logic [4:0]  out_rd;
    logic [31:0] out_rs_val, out_rt_val, out_imm, out_pc;
    logic        out_illegal;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opc     (out_opc),
        .out_rd      (out_rd),
        .out_rs_val  (out_rs_val),
        .out_rt_val  (out_rt_val),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_illegal (out_illegal),
        .stall_cnt   (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    logic [31:0] bypass_exp;

    initial begin
`ifdef DECODE_BYPASS_EN
        bypass_exp = 32'h55;
`else
        bypass_exp = 32'h0;
`endif
        #1 RST_N = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_out_opc", {26'b0, out_opc}, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        RST_N = 1'b1;
        #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // decode: r3 = 7, then ADDI rd=4 rs=3 imm=0xFFFF
        @(negedge CLK);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd7;
        @(negedge CLK);
        wb_en = 1'b0;
        feed(1'b1, 32'h0883FFFF, 32'h100);
        #1 chk("addi_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge CLK);
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_rs_val", out_rs_val, 32'd7);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_rd", {27'b0, out_rd}, 32'd4);
        chk("addi_opc", {26'b0, out_opc}, 32'd2);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_illegal", {31'b0, out_illegal}, 32'd0);
        feed(1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("idle_valid", {31'b0, out_valid}, 32'd0);

        // load-use: LW rd=5 then ADD rd=6 rs=5
        feed(1'b1, 32'h0CA00000, 32'h200);
        @(negedge CLK);
        chk("lw_valid", {31'b0, out_valid}, 32'd1);
        chk("lw_opc", {26'b0, out_opc}, 32'd3);
        chk("lw_rd", {27'b0, out_rd}, 32'd5);
        feed(1'b1, 32'h04C50000, 32'h204);
        #1 chk("lu_in_ready_stall", {31'b0, in_ready}, 32'd0);
        @(negedge CLK);
        chk("lu_bubble_valid", {31'b0, out_valid}, 32'd0);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        chk("lu_in_ready_after", {31'b0, in_ready}, 32'd1);
        @(negedge CLK);
        chk("lu_add_valid", {31'b0, out_valid}, 32'd1);
        chk("lu_add_opc", {26'b0, out_opc}, 32'd1);
        chk("lu_add_pc", out_pc, 32'h204);
        chk("lu_stall_cnt_hold", stall_cnt, 32'd1);

        // backpressure: hold ADD for 3 cycles while ADDI rd=7 rs=3 imm=5 waits
        out_ready = 1'b0;
        feed(1'b1, 32'h08E30005, 32'h300);
        #1 chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_opc", {26'b0, out_opc}, 32'd1);
            chk("bp_hold_pc", out_pc, 32'h204);
            chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        chk("bp_stall_cnt", stall_cnt, 32'd1);
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge CLK);
        chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_next_opc", {26'b0, out_opc}, 32'd2);
        chk("bp_next_pc", out_pc, 32'h300);
        chk("bp_next_rs_val", out_rs_val, 32'd7);
        chk("bp_next_imm", out_imm, 32'd5);

        // flush with bundle held and an incoming instruction
        out_ready = 1'b0;
        flush = 1'b1;
        feed(1'b1, 32'h04210000, 32'h400);
        #1 chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge CLK);
        flush = 1'b0;
        out_ready = 1'b1;
        feed(1'b0, 32'h0, 32'h0);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        @(negedge CLK);
        chk("fl_dropped", {31'b0, out_valid}, 32'd0);

        // same-cycle write r9=0x55 and read of r9
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
        feed(1'b1, 32'h04490000, 32'h500);
        @(negedge CLK);
        wb_en = 1'b0;
        chk("wb_same_cycle_rs", out_rs_val, bypass_exp);
        chk("wb_same_cycle_valid", {31'b0, out_valid}, 32'd1);
        feed(1'b1, 32'h04490000, 32'h504);
        @(negedge CLK);
        chk("wb_next_cycle_rs", out_rs_val, 32'h55);

        // illegal opcode 0x3F, then the all-zero bubble
        feed(1'b1, 32'hFC000000, 32'h600);
        @(negedge CLK);
        chk("ill_valid", {31'b0, out_valid}, 32'd1);
        chk("ill_flag", {31'b0, out_illegal}, 32'd1);
        chk("ill_opc", {26'b0, out_opc}, 32'h3F);
        feed(1'b1, 32'h00000000, 32'h604);
        #1 chk("zero_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge CLK);
        chk("zero_no_valid", {31'b0, out_valid}, 32'd0);

        // write to r0 is ignored
        feed(1'b0, 32'h0, 32'h0);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h99;
        @(negedge CLK);
        wb_en = 1'b0;
        feed(1'b1, 32'h04200000, 32'h680);
        @(negedge CLK);
        chk("r0_rs_val", out_rs_val, 32'd0);

        // load-use through rt: LW rd=8 then SW rt=8
        feed(1'b1, 32'h0D000000, 32'h700);
        @(negedge CLK);
        chk("lw8_opc", {26'b0, out_opc}, 32'd3);
        feed(1'b1, 32'h10004000, 32'h704);
        #1 chk("sw_rt_stall", {31'b0, in_ready}, 32'd0);
        @(negedge CLK);
        chk("sw_bubble", {31'b0, out_valid}, 32'd0);
        chk("sw_stall_cnt", stall_cnt, 32'd2);
        @(negedge CLK);
        feed(1'b0, 32'h0, 32'h0);
        chk("sw_valid", {31'b0, out_valid}, 32'd1);
        chk("sw_opc", {26'b0, out_opc}, 32'd4);

        // asynchronous reset mid-stream while a bundle is valid
        #2 RST_N = 1'b0;
        #1;
        chk("amid_valid", {31'b0, out_valid}, 32'd0);
        chk("amid_stall_cnt", stall_cnt, 32'd0);
        chk("amid_opc", {26'b0, out_opc}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
